// File: rtl/mux2x32_to32.sv
// Registered (or optionally combinational) 2-to-1 word multiplexer with a valid flag.
// The registered path holds the last captured word while InValid is low; only OutValid drops.
module mux2x32_to32 #(
    parameter int WIDTH      = 32,
    parameter int REGISTERED = 1
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Select,
    input  logic             InValid,
    output logic [WIDTH-1:0] DataOutput,
    output logic             OutValid
);

    logic [WIDTH-1:0] w_result;

    assign w_result = Select ? DataB : DataA;

    generate
        if (REGISTERED != 0) begin : g_registered
            logic [WIDTH-1:0] r_data;
            logic             r_valid;

            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= InValid;
                    if (InValid) begin
                        r_data <= w_result;
                    end
                end
            end

            assign DataOutput = r_data;
            assign OutValid   = r_valid;
        end else begin : g_combinational
            // Clock and ResetN are intentionally left unconnected in this mode.
            assign DataOutput = w_result;
            assign OutValid   = InValid;
        end
    endgenerate

endmodule

// File: tb/tb_mux2x32_to32.sv
// Scoreboard bench for mux2x32_to32: registered instance plus a combinational instance
// sharing the same stimulus.
module tb_mux2x32_to32;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        sel;
    logic        in_valid;
    logic [31:0] reg_out;
    logic        reg_valid;
    logic [31:0] comb_out;
    logic        comb_valid;

    exp_t        exp_q[$];
    logic [31:0] model_d;
    int          n_vec;
    int          n_bad;

    mux2x32_to32 #(.WIDTH(32), .REGISTERED(1)) dut (
        .Clock      (clk),
        .ResetN     (rst_n),
        .DataA      (data_a),
        .DataB      (data_b),
        .Select     (sel),
        .InValid    (in_valid),
        .DataOutput (reg_out),
        .OutValid   (reg_valid)
    );

    mux2x32_to32 #(.WIDTH(32), .REGISTERED(0)) dut_comb (
        .Clock      (clk),
        .ResetN     (rst_n),
        .DataA      (data_a),
        .DataB      (data_b),
        .Select     (sel),
        .InValid    (in_valid),
        .DataOutput (comb_out),
        .OutValid   (comb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one input set and pushes the expected registered result; returns one edge later.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic v);
        exp_t e;
        data_a   = a;
        data_b   = b;
        sel      = s;
        in_valid = v;
        if (v) model_d = s ? b : a;
        e.v = v;
        e.d = model_d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        data_a   = 32'hFFFFFFFF;
        data_b   = 32'h0;
        sel      = 1'b0;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({reg_valid, reg_out} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_async: got valid=%b data=%h, want valid=0 data=00000000", reg_valid, reg_out);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({reg_valid, reg_out} !== {1'b0, 32'h0}) begin
                n_bad++;
                $display("FAIL reset_hold: got valid=%b data=%h, want valid=0 data=00000000", reg_valid, reg_out);
            end
        end
        model_d = 32'h0;
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_select_a();
        exp_t e;
        drive(32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if ({reg_valid, reg_out} !== {e.v, e.d} || e.d !== 32'hFFFFFFFF) begin
            n_bad++;
            $display("FAIL select_a: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
        end
    endtask

    task automatic test_select_b();
        exp_t e;
        drive(32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if ({reg_valid, reg_out} !== {e.v, e.d}) begin
            n_bad++;
            $display("FAIL select_b: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if ({reg_valid, reg_out} !== {e.v, e.d}) begin
            n_bad++;
            $display("FAIL hold_load: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
        end
        for (int i = 0; i < 2; i++) begin
            drive(32'h0, 32'h5A5A5A5A, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_vec++;
            if ({reg_valid, reg_out} !== {e.v, e.d} || reg_out !== 32'hA5A5A5A5) begin
                n_bad++;
                $display("FAIL hold_invalid: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(32'h12345678, 32'h87654321, 1'(i % 2), 1'b1);
            e = exp_q.pop_front();
            n_vec++;
            if ({reg_valid, reg_out} !== {e.v, e.d}) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got valid=%b data=%h, want valid=%b data=%h", i, reg_valid, reg_out, e.v, e.d);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            e = exp_q.pop_front();
            n_vec++;
            if ({reg_valid, reg_out} !== {e.v, e.d}) begin
                n_bad++;
                $display("FAIL random[%0d]: got valid=%b data=%h, want valid=%b data=%h", i, reg_valid, reg_out, e.v, e.d);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        drive(32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if ({reg_valid, reg_out} !== {e.v, e.d}) begin
            n_bad++;
            $display("FAIL midreset_load: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
        end
        // An in-flight word is presented, then reset lands before its capture edge.
        data_a   = 32'h0;
        data_b   = 32'hDEADBEEF;
        sel      = 1'b1;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({reg_valid, reg_out} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL midreset_clear: got valid=%b data=%h, want valid=0 data=00000000", reg_valid, reg_out);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({reg_valid, reg_out} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL midreset_wins: got valid=%b data=%h, want valid=0 data=00000000", reg_valid, reg_out);
        end
        model_d = 32'h0;
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        drive(32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if ({reg_valid, reg_out} !== {e.v, e.d}) begin
            n_bad++;
            $display("FAIL midreset_noreplay: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
        end
        drive(32'h0, 32'h13579BDF, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if ({reg_valid, reg_out} !== {e.v, e.d}) begin
            n_bad++;
            $display("FAIL midreset_resume: got valid=%b data=%h, want valid=%b data=%h", reg_valid, reg_out, e.v, e.d);
        end
    endtask

    task automatic test_comb();
        logic [31:0] a_v[3];
        logic [31:0] b_v[3];
        a_v = '{32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00000001};
        b_v = '{32'h00000000, 32'hF0F0F0F0, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++) begin
                for (int v = 0; v < 2; v++) begin
                    data_a   = a_v[i];
                    data_b   = b_v[i];
                    sel      = 1'(s);
                    in_valid = 1'(v);
                    #1;
                    n_vec++;
                    if ({comb_valid, comb_out} !== {1'(v), (s != 0) ? b_v[i] : a_v[i]}) begin
                        n_bad++;
                        $display("FAIL comb[%0d,%0d,%0d]: got valid=%b data=%h, want valid=%b data=%h",
                                 i, s, v, comb_valid, comb_out, 1'(v), (s != 0) ? b_v[i] : a_v[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        model_d = 32'h0;
        test_reset();
        test_select_a();
        test_select_b();
        test_hold();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_comb();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
